ldpc_job_scheduler: RTL and testbench
=====================================

# ldpc_job_scheduler

Shares one `ldpc_decoder_top` instance between up to `NUM_REQ` code-block requesters. It arbitrates round-robin, latches the winning job's configuration, and sequences the decoder's `start_decode` and `llr_valid`. It then waits for `decode_done` and returns a tagged result to the requester side. It sits between the de-rate-matching front end and the decoder core, one per decoder instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_ITER`, 15: iteration ceiling; requested values are clamped to it.
- `TIMEOUT_CYCLES`, 65535: watchdog limit in decoder-busy cycles (used only with `LDPC_SCHED_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester job pending.
- `req_cfg` in `NUM_REQ` x `ldpc_job_cfg_t`: per-requester configuration; must be stable while `req_valid` is high.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `dec_start` out 1: one-cycle pulse to the decoder's `start_decode`.
- `dec_llr_valid` out 1: drives the decoder's `llr_valid`.
- `dec_cfg` out `ldpc_job_cfg_t`: latched job configuration; drives `code_rate_sel`, `lifting_factor_z`, `base_graph_sel` and `max_iter`.
- `dec_done` in 1: decoder `decode_done`.
- `dec_success` in 1: decoder `decode_success`.
- `dec_iters` in 5: decoder `iterations_used`.
- `dec_abort` out 1: decoder soft-abort pulse; present only with `LDPC_SCHED_TIMEOUT_EN`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out `$clog2(NUM_REQ)`: index of the requester that owns the result.
- `rsp_success` out 1: decode success flag.
- `rsp_iters` out 5: iterations used.
- `rsp_timeout` out 1: job was aborted by the watchdog.
- `frames_done` out 16: completed-job counter; wraps.
- `frames_failed` out 16: count of jobs with `rsp_success=0`; saturates at 16'hFFFF.

## Operation
The FSM states are `IDLE`, `START`, `BUSY` and `RESP`.

- **IDLE**
  - The round-robin arbiter picks the first `req_valid` at or after `rr_ptr`.
  - `req_ready[g]` is asserted in the same cycle.
  - On transfer: latch `req_cfg[g]` into `dec_cfg`, latch `g` as the job id, set `rr_ptr = (g+1) mod NUM_REQ`, and go to `START`.
  - If no `req_valid` is high, stay in `IDLE` and leave `rr_ptr` unchanged.
- **START**
  - `dec_start=1` and `dec_llr_valid=1` for exactly one cycle, then go to `BUSY`.
- **BUSY**
  - `dec_llr_valid` stays at 1.
  - On `dec_done`: latch `dec_success` and `dec_iters`, then go to `RESP`.
  - `dec_done` is sampled only in `BUSY`.
- **RESP**
  - `dec_llr_valid` stays at 1 for the first `RESP` cycle only, then drops to 0.
  - `rsp_valid=1` and all `rsp_*` outputs are held until `rsp_ready`.
  - On the handshake: update the counters and go to `IDLE`.
- **Iteration clamp:** if `req_cfg.max_iter` is 0 or greater than `MAX_ITER`, `dec_cfg.max_iter = MAX_ITER`.
- **Simultaneous `rsp_ready` and `req_valid`:** the new grant is not issued in the handshake cycle; the earliest grant is in the following `IDLE` cycle.
- **Reset** (including mid-operation):
  - State returns to `IDLE`.
  - `rr_ptr=0`.
  - All outputs are 0, including `dec_cfg`, both counters, `req_ready` and `dec_abort`.
  - There is no pending response after reset; an in-flight job is dropped.

## Timing
- Request handshake in cycle T → `dec_start` high in T+1 → `BUSY` from T+2.
- `dec_done` in cycle D → `rsp_valid` high in D+1.
- Response handshake in cycle R → `IDLE` in R+1 → earliest next grant in R+1.
- Minimum job period is 4 cycles plus the decoder latency.
- Counters update in the cycle after the response handshake.
- `req_ready` is combinational from `req_valid` and the state; every other output is registered.

## Configuration
`LDPC_SCHED_TIMEOUT_EN`:
- **Defined:**
  - A 16-bit busy counter clears in `START` and increments in `BUSY`.
  - When it reaches `TIMEOUT_CYCLES` without `dec_done`:
    - `dec_abort` pulses for 1 cycle and the FSM goes to `RESP`.
    - The response carries `rsp_timeout=1`, `rsp_success=0` and `rsp_iters = dec_cfg.max_iter`.
  - If `dec_done` and the timeout occur in the same cycle, `dec_done` wins and `rsp_timeout=0`.
- **Undefined:**
  - The FSM waits in `BUSY` indefinitely.
  - The `dec_abort` port is absent.
  - `rsp_timeout` is tied to 0.

## Structure
- In `ldpc_decoder_pkg`:
  - `ldpc_job_cfg_t`, a packed struct with `rate_sel[2:0]`, `z[8:0]`, `bg_sel[3:0]` and `max_iter[4:0]`.
  - `sched_state_t`, the enum of FSM states.
- Sub-module `ldpc_rr_arbiter`, parameterised by `NUM_REQ`:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant and its index.
  - Combinational.

## Test plan
- **Single job:**
  - Stimulus: `req_valid[2]=1`, max_iter=10; the decoder model asserts `dec_done` 20 cycles after start with iters=6 and success=1.
  - Response: `rsp_id=2`, `rsp_iters=6`, `rsp_success=1`, `frames_done=1`; `dec_start` is high for exactly one cycle.
- **Round-robin:** all 4 requesters continuously valid for 8 jobs → grant order 0,1,2,3,0,1,2,3.
- **Clamp:** max_iter=0 → `dec_cfg.max_iter=15`; max_iter=20 → `dec_cfg.max_iter=15`; max_iter=7 → 7.
- **Backpressure:**
  - Stimulus: `rsp_ready=0` for 50 cycles while `req_valid[1]=1`.
  - Response: the `rsp_*` outputs hold stable; no new `dec_start`; `req_ready=0`.
- **Reset mid-`BUSY`:**
  - Stimulus: `rst_n=0` for 1 cycle.
  - Response: next cycle in `IDLE`, all outputs 0, `rr_ptr=0`; the next grant goes to the lowest valid index.
- **Timeout** (`LDPC_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES=100`):
  - Stimulus: the decoder never asserts `dec_done`.
  - Response: one-cycle `dec_abort` pulse; `rsp_timeout=1`, `rsp_success=0`; `frames_failed=1`.

Source files
------------

// File: rtl/ldpc_decoder_pkg.sv
// Shared types for the LDPC decoder front end: job configuration record,
// scheduler FSM states and the iteration-ceiling helper.
package ldpc_decoder_pkg;

  typedef struct packed {
    logic [2:0] rate_sel;
    logic [8:0] z;
    logic [3:0] bg_sel;
    logic [4:0] max_iter;
  } ldpc_job_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } sched_state_t;

  // A request of 0 means "no preference", so it gets the ceiling as well.
  function automatic logic [4:0] clamp_iter(input logic [4:0] req, input logic [4:0] lim);
    return (req == 5'd0 || req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/ldpc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// rr_ptr_i, returning both the one-hot grant and its index.
module ldpc_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot_req;
  logic               found;

  // rot_req[0] is the requester that currently holds top priority.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot_req[gi] = req_i[IDW'((int'(rr_ptr_i) + gi) % NUM_REQ)];
  end

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_req[k]) begin
        found       = 1'b1;
        grant_idx_o = IDW'((int'(rr_ptr_i) + k) % NUM_REQ);
      end
    end
    if (found) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/ldpc_job_scheduler.sv
// Shares one LDPC decoder between NUM_REQ requesters: round-robin grant,
// start/llr sequencing and tagged response. Watchdog: LDPC_SCHED_TIMEOUT_EN.
module ldpc_job_scheduler
  import ldpc_decoder_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_ITER       = 15,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  ldpc_job_cfg_t [NUM_REQ-1:0]  req_cfg,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         dec_start,
  output logic                         dec_llr_valid,
  output ldpc_job_cfg_t                dec_cfg,
  input  logic                         dec_done,
  input  logic                         dec_success,
  input  logic [4:0]                   dec_iters,
`ifdef LDPC_SCHED_TIMEOUT_EN
  output logic                         dec_abort,
`endif
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         rsp_success,
  output logic [4:0]                   rsp_iters,
  output logic                         rsp_timeout,
  output logic [15:0]                  frames_done,
  output logic [15:0]                  frames_failed
);

  localparam int         IDW      = $clog2(NUM_REQ);
  localparam logic [4:0] ITER_LIM = 5'(MAX_ITER);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("ldpc_job_scheduler: parameter out of range");
  end

  sched_state_t   state_q;
  logic [IDW-1:0] rr_ptr_q, job_id_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  ldpc_job_cfg_t  dec_cfg_q, cfg_d;
  logic           dec_start_q, llr_valid_q, rsp_valid_q, rsp_success_q;
  logic [4:0]     rsp_iters_q;
  logic [15:0]    frames_done_q, frames_failed_q;

  ldpc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (gnt),
    .grant_idx_o (gnt_idx)
  );

  // Grant only in IDLE and never while reset is being applied.
  assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;

  always_comb begin
    cfg_d          = req_cfg[gnt_idx];
    cfg_d.max_iter = clamp_iter(cfg_d.max_iter, ITER_LIM);
  end

`ifdef LDPC_SCHED_TIMEOUT_EN
  localparam logic [15:0] BUSY_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] busy_cnt_q;
  logic        dec_abort_q, rsp_timeout_q;
  assign dec_abort   = dec_abort_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      job_id_q        <= '0;
      dec_cfg_q       <= '0;
      dec_start_q     <= 1'b0;
      llr_valid_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_success_q   <= 1'b0;
      rsp_iters_q     <= '0;
      frames_done_q   <= '0;
      frames_failed_q <= '0;
`ifdef LDPC_SCHED_TIMEOUT_EN
      busy_cnt_q      <= '0;
      dec_abort_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
`endif
    end else begin
      dec_start_q <= 1'b0;
`ifdef LDPC_SCHED_TIMEOUT_EN
      dec_abort_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (|req_ready) begin
            dec_cfg_q   <= cfg_d;
            job_id_q    <= gnt_idx;
            rr_ptr_q    <= IDW'((int'(gnt_idx) + 1) % NUM_REQ);
            dec_start_q <= 1'b1;
            llr_valid_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
`ifdef LDPC_SCHED_TIMEOUT_EN
          busy_cnt_q <= '0;
`endif
          state_q <= BUSY;
        end
        BUSY: begin
          // A done arriving in the watchdog's final cycle still counts as a real result.
          if (dec_done) begin
            rsp_success_q <= dec_success;
            rsp_iters_q   <= dec_iters;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
`ifdef LDPC_SCHED_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (busy_cnt_q >= BUSY_LAST) begin
            dec_abort_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_success_q <= 1'b0;
            rsp_iters_q   <= dec_cfg_q.max_iter;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            busy_cnt_q <= busy_cnt_q + 16'd1;
`endif
          end
        end
        RESP: begin
          llr_valid_q <= 1'b0;
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            frames_done_q <= frames_done_q + 16'd1;
            if (!rsp_success_q && frames_failed_q != 16'hFFFF)
              frames_failed_q <= frames_failed_q + 16'd1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign dec_start     = dec_start_q;
  assign dec_llr_valid = llr_valid_q;
  assign dec_cfg       = dec_cfg_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = job_id_q;
  assign rsp_success   = rsp_success_q;
  assign rsp_iters     = rsp_iters_q;
  assign frames_done   = frames_done_q;
  assign frames_failed = frames_failed_q;

endmodule

// File: tb/tb_ldpc_job_scheduler.sv
// Bench for ldpc_job_scheduler: vector table, hand sequences for backpressure
// and mid-job reset, random jobs against a model; watchdog case with LDPC_SCHED_TIMEOUT_EN.
module tb_ldpc_job_scheduler;
  import ldpc_decoder_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [3:0]              req_valid;
  ldpc_job_cfg_t [3:0]     req_cfg;
  logic [3:0]              req_ready;
  logic                    dec_start, dec_llr_valid;
  ldpc_job_cfg_t           dec_cfg;
  logic                    dec_done, dec_success;
  logic [4:0]              dec_iters;
`ifdef LDPC_SCHED_TIMEOUT_EN
  logic                    dec_abort;
`endif
  logic                    rsp_valid, rsp_ready;
  logic [1:0]              rsp_id;
  logic                    rsp_success, rsp_timeout;
  logic [4:0]              rsp_iters;
  logic [15:0]             frames_done, frames_failed;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  logic [15:0] done_m = 0, failed_m = 0;

  always #5 clk = ~clk;

  ldpc_job_scheduler #(.NUM_REQ(4), .MAX_ITER(15), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cfg(req_cfg),
    .req_ready(req_ready), .dec_start(dec_start), .dec_llr_valid(dec_llr_valid),
    .dec_cfg(dec_cfg), .dec_done(dec_done), .dec_success(dec_success),
    .dec_iters(dec_iters),
`ifdef LDPC_SCHED_TIMEOUT_EN
    .dec_abort(dec_abort),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_success(rsp_success), .rsp_iters(rsp_iters), .rsp_timeout(rsp_timeout),
    .frames_done(frames_done), .frames_failed(frames_failed)
  );

  typedef struct {
    logic [3:0] vmask;
    logic [4:0] mi;
    int         lat;
    logic       succ;
    logic [4:0] it;
    int         exp_id;
    logic [4:0] exp_mi;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic ldpc_job_cfg_t cfg_of(input int i, input logic [4:0] mi);
    ldpc_job_cfg_t c;
    c.rate_sel = 3'(i + 1);
    c.z        = 9'(40 * i + 7);
    c.bg_sel   = 4'(i + 2);
    c.max_iter = mi;
    return c;
  endfunction

  // Reference: first requester at or after the pointer, and the iteration ceiling.
  function automatic int pick(input logic [3:0] vmask, input int ptr);
    for (int k = 0; k < 4; k++)
      if (vmask[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [4:0] clamp_m(input logic [4:0] mi);
    return (mi == 0 || mi > 15) ? 5'd15 : mi;
  endfunction

  function automatic logic [31:0] outs_or();
    return 32'(dec_start | dec_llr_valid | (|dec_cfg) | rsp_valid | (|rsp_id) | rsp_success
             | (|rsp_iters) | rsp_timeout | (|frames_done) | (|frames_failed) | (|req_ready));
  endfunction

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_job(input logic [3:0] vmask, input logic [4:0] mi, input int lat,
                         input logic succ, input logic [4:0] it, input int exp_id,
                         input logic [4:0] exp_mi, input int bp);
    ldpc_job_cfg_t exp_cfg;
    bit hold_ok;
    int nxt;
    for (int i = 0; i < 4; i++) req_cfg[i] = cfg_of(i, mi);
    req_valid = vmask;
    #1;
    check(req_ready == 4'(1 << exp_id), "grant", 32'(req_ready), 32'(1 << exp_id));
    @(negedge clk);
    check(dec_start && dec_llr_valid, "start", {30'd0, dec_start, dec_llr_valid}, 32'd3);
    exp_cfg = cfg_of(exp_id, exp_mi);
    check(dec_cfg == exp_cfg, "dec_cfg", 32'(dec_cfg), 32'(exp_cfg));
    check(req_ready == 0, "ready_start", 32'(req_ready), 0);
    ptr_m = (exp_id + 1) % 4;
    hold_ok = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (dec_start || !dec_llr_valid || rsp_valid || req_ready != 0) hold_ok = 1'b0;
    end
    check(hold_ok, "busy_phase", 32'(hold_ok), 1);
    dec_done = 1'b1; dec_success = succ; dec_iters = it;
    @(negedge clk);
    dec_done = 1'b0; dec_success = 1'b0; dec_iters = 5'd0;
    check(rsp_valid && dec_llr_valid && rsp_id == 2'(exp_id) && rsp_success == succ
          && rsp_iters == it && !rsp_timeout,
          "rsp", {rsp_valid, dec_llr_valid, rsp_id, rsp_success, rsp_iters, rsp_timeout},
          {1'b1, 1'b1, 2'(exp_id), succ, it, 1'b0});
    hold_ok = 1'b1;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_id != 2'(exp_id) || rsp_success != succ || rsp_iters != it
          || dec_start || dec_llr_valid || req_ready != 0) hold_ok = 1'b0;
      // A stray done outside BUSY must be ignored.
      dec_done = b[0]; dec_success = ~succ; dec_iters = ~it;
    end
    dec_done = 1'b0; dec_success = 1'b0; dec_iters = 5'd0;
    if (bp > 0) check(hold_ok, "rsp_hold", 32'(hold_ok), 1);
    rsp_ready = 1'b1;
    #1;
    check(req_ready == 0, "no_grant_in_hs", 32'(req_ready), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    done_m = done_m + 16'd1;
    if (!succ && failed_m != 16'hFFFF) failed_m = failed_m + 16'd1;
    nxt = pick(vmask, ptr_m);
    check(!rsp_valid && frames_done == done_m && frames_failed == failed_m
          && req_ready == 4'(1 << nxt), "after_hs",
          {rsp_valid, frames_done, frames_failed[14:0]}, {1'b0, done_m, failed_m[14:0]});
    $display("[TB] job id=%0d mi=%0d->%0d lat=%0d succ=%0d it=%0d bp=%0d", exp_id, mi, exp_mi, lat, succ, it, bp);
    req_valid = 4'd0;
  endtask

  initial begin
    int id;
    logic [3:0] vm;
    logic [4:0] mi;
    rst_n = 1'b0; req_valid = 0; req_cfg = '0; dec_done = 0; dec_success = 0;
    dec_iters = 0; rsp_ready = 0;
    tbl[0]  = '{4'b0100, 5'd10, 20, 1'b1, 5'd6,  2, 5'd10};
    tbl[1]  = '{4'b0001, 5'd0,  3,  1'b0, 5'd15, 0, 5'd15};
    tbl[2]  = '{4'b0011, 5'd20, 4,  1'b1, 5'd9,  1, 5'd15};
    tbl[3]  = '{4'b1001, 5'd7,  2,  1'b1, 5'd3,  3, 5'd7};
    for (int i = 0; i < 8; i++)
      tbl[4 + i] = '{4'b1111, 5'(i + 1), 1 + i, 1'(i % 3 != 0), 5'(i), i % 4, 5'(i + 1)};

    repeat (3) @(negedge clk);
    check(outs_or() == 0, "reset_outs", outs_or(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_job(tbl[i].vmask, tbl[i].mi, tbl[i].lat, tbl[i].succ, tbl[i].it,
              tbl[i].exp_id, tbl[i].exp_mi, 0);

    // Backpressure: response held for 50 cycles while requester 1 waits.
    id = pick(4'b0010, ptr_m);
    run_job(4'b0010, 5'd12, 5, 1'b0, 5'd12, id, 5'd12, 50);

    // Reset in the middle of BUSY drops the job and restarts the pointer.
    for (int i = 0; i < 4; i++) req_cfg[i] = cfg_of(i, 5'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(outs_or() == 0, "reset_mid_busy", outs_or(), 0);
    $display("[TB] reset applied mid-BUSY");
    ptr_m = 0; done_m = 0; failed_m = 0;
    @(negedge clk);
    check(dec_start == 0 && rsp_valid == 0, "no_stale_job", {dec_start, rsp_valid}, 0);
    run_job(4'b1010, 5'd4, 2, 1'b1, 5'd3, 1, 5'd4, 0);

    for (int n = 0; n < 40; n++) begin
      vm = 4'($urandom_range(1, 15));
      mi = 5'($urandom_range(0, 31));
      id = pick(vm, ptr_m);
      run_job(vm, mi, $urandom_range(1, 8), 1'($urandom), 5'($urandom), id, clamp_m(mi),
              $urandom_range(0, 3));
    end

`ifdef LDPC_SCHED_TIMEOUT_EN
    begin
      int aborts, waited;
      for (int i = 0; i < 4; i++) req_cfg[i] = cfg_of(i, 5'd9);
      req_valid = 4'b0001;
      id = pick(4'b0001, ptr_m);
      @(negedge clk);
      req_valid = 4'b0;
      ptr_m = (id + 1) % 4;
      aborts = 0; waited = 0;
      while (!rsp_valid && waited < 300) begin
        @(negedge clk);
        waited++;
        if (dec_abort) aborts++;
      end
      check(rsp_valid, "timeout_rsp_seen", 32'(rsp_valid), 1);
      repeat (3) begin
        @(negedge clk);
        if (dec_abort) aborts++;
      end
      check(aborts == 1, "abort_pulse", 32'(aborts), 1);
      check(rsp_timeout && !rsp_success && rsp_iters == 5'd9, "timeout_rsp",
            {rsp_timeout, rsp_success, rsp_iters}, {1'b1, 1'b0, 5'd9});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      failed_m = failed_m + 16'd1;
      check(frames_failed == failed_m, "timeout_failed_cnt", 32'(frames_failed), 32'(failed_m));
      $display("[TB] watchdog job id=%0d aborts=%0d", id, aborts);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
